// File: rtl/membus_arbiter_2to1_if.sv
// membus_arbiter_2to1_if: one membus link (request + in-order response).
//   valid/ready/addr/wen/wdata : request channel, master -> slave
//   rvalid/rdata               : response channel, slave -> master
// Modports: master (issues requests), slave (serves requests).
interface membus_arbiter_2to1_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output valid, addr, wen, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/membus_arbiter_2to1.sv
// membus_arbiter_2to1: two membus masters (I = fetch, D = load/store) sharing one
// memory slave. One request is forwarded per cycle; an in-order owner queue remembers
// which master issued each accepted request so responses are routed back.
//
// Ports:
//   clk    : clock, all state on rising edge
//   rst    : asynchronous active-low reset
//   i_bus  : slave side of master I link
//   d_bus  : slave side of master D link
//   s_bus  : master side of the memory link
//   busy   : owner queue non-empty
//
// Optional feature: define MEMBUS_ARBITER_ROUND_ROBIN_EN to replace fixed D>I priority
// with a round-robin pointer for contested grants.
module membus_arbiter_2to1 #(
  parameter int unsigned ADDR_WIDTH      = 20,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  membus_arbiter_2to1_if.slave  i_bus,
  membus_arbiter_2to1_if.slave  d_bus,
  membus_arbiter_2to1_if.master s_bus,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(MAX_OUTSTANDING);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {LockNone, LockI, LockD} lock_e;

  lock_e           lock_q;
  logic            owner_q [MAX_OUTSTANDING];  // 0 = I, 1 = D
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic full;
  logic empty;
  logic both_valid;
  logic grant_d;
  logic req_valid;
  logic fwd_valid;
  logic fire;
  logic pop;
  logic head_d;

`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
  logic prio_d_q;  // 1 = D wins the next contested grant
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + 1'b1;
  endfunction

  // Fullness uses the registered count only, so a same-cycle pop never frees a slot.
  assign full  = (count_q == CntMax);
  assign empty = (count_q == '0);
  assign busy  = !empty;

  always_comb begin
    both_valid = i_bus.valid && d_bus.valid;
    grant_d    = d_bus.valid;
    unique case (lock_q)
      LockI:   grant_d = 1'b0;
      LockD:   grant_d = 1'b1;
      default: begin
`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
        if (both_valid) grant_d = prio_d_q;
`else
        if (both_valid) grant_d = 1'b1;
`endif
      end
    endcase

    req_valid = grant_d ? d_bus.valid : i_bus.valid;
    fwd_valid = req_valid && !full;
    fire      = fwd_valid && s_bus.ready;

    s_bus.valid = fwd_valid;
    s_bus.addr  = grant_d ? d_bus.addr  : i_bus.addr;
    s_bus.wen   = grant_d ? d_bus.wen   : i_bus.wen;
    s_bus.wdata = grant_d ? d_bus.wdata : i_bus.wdata;

    // Ready is only raised to the granted master, and only when its request fires.
    i_bus.ready = fire && !grant_d;
    d_bus.ready = fire && grant_d;
  end

  // Responses with an empty queue are orphans (pre-reset traffic) and are dropped.
  always_comb begin
    pop          = s_bus.rvalid && !empty;
    head_d       = owner_q[rd_ptr_q];
    i_bus.rvalid = pop && !head_d;
    d_bus.rvalid = pop && head_d;
    i_bus.rdata  = s_bus.rdata;
    d_bus.rdata  = s_bus.rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q   <= LockNone;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < MAX_OUTSTANDING; k++) begin
        owner_q[k] <= 1'b0;
      end
    end else begin
      // Lock holds the grant on a stalled request so the memory sees a stable payload.
      if (fire) begin
        lock_q <= LockNone;
      end else if (fwd_valid) begin
        lock_q <= grant_d ? LockD : LockI;
      end

      if (fire) begin
        owner_q[wr_ptr_q] <= grant_d;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end

      if (fire && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !fire) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
  // Flip after any fire where the other master was also requesting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio_d_q <= 1'b1;
    end else if (fire && both_valid) begin
      prio_d_q <= !grant_d;
    end
  end
`endif

`ifndef SYNTHESIS
  lock_hold_i: assert property (@(posedge clk) disable iff (!rst)
    (lock_q == LockI) |-> i_bus.valid)
    else $error("membus_arbiter_2to1: master I dropped valid while locked");

  lock_hold_d: assert property (@(posedge clk) disable iff (!rst)
    (lock_q == LockD) |-> d_bus.valid)
    else $error("membus_arbiter_2to1: master D dropped valid while locked");

  always @(posedge clk) begin
    if (rst && s_bus.rvalid && empty) begin
      $warning("membus_arbiter_2to1: orphan response dropped");
    end
  end
`endif

endmodule

// File: tb/tb_membus_arbiter_2to1.sv
// Directed, table-driven bench for membus_arbiter_2to1 (MAX_OUTSTANDING = 2).
// The bench plays the memory by driving s_ready / s_rvalid / s_rdata per vector.
module tb_membus_arbiter_2to1;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;

`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
  localparam bit Rr = 1'b1;
`else
  localparam bit Rr = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  membus_arbiter_2to1_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) i_bus ();
  membus_arbiter_2to1_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) d_bus ();
  membus_arbiter_2to1_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_bus ();

  membus_arbiter_2to1 #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MAX_OUTSTANDING(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .i_bus(i_bus),
    .d_bus(d_bus),
    .s_bus(s_bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    // stimulus
    logic          iv;
    logic [AW-1:0] ia;
    logic          iw;
    logic [DW-1:0] iwd;
    logic          dv;
    logic [AW-1:0] da;
    logic          dw;
    logic [DW-1:0] dwd;
    logic          sr;
    logic          srv;
    logic [DW-1:0] srd;
    // expected
    logic          sv;
    logic [AW-1:0] sa;
    logic          sw;
    logic [DW-1:0] swd;
    logic          ir;
    logic          dr;
    logic          irv;
    logic          drv;
    logic          bz;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input logic iv, input logic [AW-1:0] ia, input logic iw, input logic [DW-1:0] iwd,
    input logic dv, input logic [AW-1:0] da, input logic dw, input logic [DW-1:0] dwd,
    input logic sr, input logic srv, input logic [DW-1:0] srd,
    input logic sv, input logic [AW-1:0] sa, input logic sw, input logic [DW-1:0] swd,
    input logic ir, input logic dr, input logic irv, input logic drv, input logic bz,
    input logic [DW-1:0] rd);
    vec_t v;
    v.iv = iv; v.ia = ia; v.iw = iw; v.iwd = iwd;
    v.dv = dv; v.da = da; v.dw = dw; v.dwd = dwd;
    v.sr = sr; v.srv = srv; v.srd = srd;
    v.sv = sv; v.sa = sa; v.sw = sw; v.swd = swd;
    v.ir = ir; v.dr = dr; v.irv = irv; v.drv = drv; v.bz = bz; v.rd = rd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    i_bus.valid  = v.iv;
    i_bus.addr   = v.ia;
    i_bus.wen    = v.iw;
    i_bus.wdata  = v.iwd;
    d_bus.valid  = v.dv;
    d_bus.addr   = v.da;
    d_bus.wen    = v.dw;
    d_bus.wdata  = v.dwd;
    s_bus.ready  = v.sr;
    s_bus.rvalid = v.srv;
    s_bus.rdata  = v.srd;
  endtask

  task automatic check(input vec_t v, input int id);
    logic ok;
    ok = 1'b1;
    if (s_bus.valid !== v.sv) ok = 1'b0;
    if (v.sv && (s_bus.addr !== v.sa || s_bus.wen !== v.sw || s_bus.wdata !== v.swd)) ok = 1'b0;
    if (i_bus.ready !== v.ir || d_bus.ready !== v.dr) ok = 1'b0;
    if (i_bus.rvalid !== v.irv || d_bus.rvalid !== v.drv) ok = 1'b0;
    if (busy !== v.bz) ok = 1'b0;
    if (v.irv && i_bus.rdata !== v.rd) ok = 1'b0;
    if (v.drv && d_bus.rdata !== v.rd) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display({"FAIL vec %0d: got sv=%b sa=%h sw=%b swd=%h ir=%b dr=%b irv=%b drv=%b ",
                "busy=%b ird=%h drd=%h; want sv=%b sa=%h sw=%b swd=%h ir=%b dr=%b irv=%b ",
                "drv=%b busy=%b rd=%h"},
               id, s_bus.valid, s_bus.addr, s_bus.wen, s_bus.wdata, i_bus.ready,
               d_bus.ready, i_bus.rvalid, d_bus.rvalid, busy, i_bus.rdata, d_bus.rdata,
               v.sv, v.sa, v.sw, v.swd, v.ir, v.dr, v.irv, v.drv, v.bz, v.rd);
    end
  endtask

  // One cycle: drive after the falling edge, sample before the next rising edge.
  task automatic apply(input vec_t v, input int id);
    @(negedge clk);
    drive(v);
    #1;
    check(v, id);
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    logic g;
    logic prev_g;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    #2;
    check(idle, 0);  // reset state
    @(negedge clk);
    rst = 1'b1;

    // Single read from I, 1-cycle memory
    vecs.push_back(mk(1, 'h00010, 0, 0, 0, 0, 0, 0, 1, 0, 0,
                      1, 'h00010, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF,
                      0, 0, 0, 0, 0, 0, 1, 0, 1, 'hDEADBEEF));
    vecs.push_back(idle);
    // Lock: I stalls 3 cycles at 0x004, D arrives in cycle 2, I fires then D
    vecs.push_back(mk(1, 'h004, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                      1, 'h004, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h004, 0, 0, 1, 'h200, 0, 0, 0, 0, 0,
                      1, 'h004, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h004, 0, 0, 1, 'h200, 0, 0, 0, 0, 0,
                      1, 'h004, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 'h004, 0, 0, 1, 'h200, 0, 0, 1, 0, 0,
                      1, 'h004, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h200, 0, 0, 1, 0, 0,
                      1, 'h200, 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h11111111,
                      0, 0, 0, 0, 0, 0, 1, 0, 1, 'h11111111));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h22222222,
                      0, 0, 0, 0, 0, 0, 0, 1, 1, 'h22222222));
    vecs.push_back(idle);
    // Queue full: D back-to-back, slow memory; third fire the cycle after the first pop
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h300, 0, 0, 1, 0, 0,
                      1, 'h300, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h301, 0, 0, 1, 0, 0,
                      1, 'h301, 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h302, 0, 0, 1, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h302, 0, 0, 1, 0, 0,
                      0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h302, 0, 0, 1, 1, 'hA0000300,
                      0, 0, 0, 0, 0, 0, 0, 1, 1, 'hA0000300));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h302, 0, 0, 1, 0, 0,
                      1, 'h302, 0, 0, 0, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hA0000301,
                      0, 0, 0, 0, 0, 0, 0, 1, 1, 'hA0000301));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hA0000302,
                      0, 0, 0, 0, 0, 0, 0, 1, 1, 'hA0000302));
    // D write then read of 0x3FF; the read fires in the same cycle as the write ack
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h3FF, 1, 'h12345678, 1, 0, 0,
                      1, 'h3FF, 1, 'h12345678, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 'h3FF, 0, 0, 1, 1, 0,
                      1, 'h3FF, 0, 0, 0, 1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h12345678,
                      0, 0, 0, 0, 0, 0, 0, 1, 1, 'h12345678));
    vecs.push_back(idle);
    // I write: payload muxed from I, ack routed to I, then an orphan response
    vecs.push_back(mk(1, 'h055, 1, 'hCAFEF00D, 0, 0, 0, 0, 1, 0, 0,
                      1, 'h055, 1, 'hCAFEF00D, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h5A5A5A5A,
                      0, 0, 0, 0, 0, 0, 1, 0, 1, 'h5A5A5A5A));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h0BADF00D,
                      0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      apply(vecs[k], k + 1);
    end

    // Contention: both masters valid for 4 cycles, 1-cycle memory
    prev_g = 1'b0;
    for (int k = 0; k < 4; k++) begin
      g = Rr ? (k % 2 == 0) : 1'b1;
      v = mk(1, 'h100, 0, 0, 1, 'h200, 0, 0, 1, k > 0, DW'(32'hC0 + k),
             1, g ? AW'('h200) : AW'('h100), 0, 0, !g, g,
             (k > 0) && !prev_g, (k > 0) && prev_g, k > 0, DW'(32'hC0 + k));
      apply(v, 100 + k);
      prev_g = g;
    end
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hC4,
             0, 0, 0, 0, 0, 0, !prev_g, prev_g, 1, 'hC4), 104);
    apply(idle, 105);

    // Reset with two requests in flight; stale responses must be dropped
    apply(mk(1, 'h040, 0, 0, 0, 0, 0, 0, 1, 0, 0,
             1, 'h040, 0, 0, 1, 0, 0, 0, 0, 0), 200);
    apply(mk(0, 0, 0, 0, 1, 'h041, 0, 0, 1, 0, 0,
             1, 'h041, 0, 0, 0, 1, 0, 0, 1, 0), 201);
    @(negedge clk);
    drive(idle);
    rst = 1'b0;
    #1;
    check(idle, 202);
    @(negedge clk);
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h0F0F0F0F,
             0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 203);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hF0F0F0F0,
             0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 204);
    apply(mk(1, 'h050, 0, 0, 0, 0, 0, 0, 1, 0, 0,
             1, 'h050, 0, 0, 1, 0, 0, 0, 0, 0), 205);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hABCD0123,
             0, 0, 0, 0, 0, 0, 1, 0, 1, 'hABCD0123), 206);
    apply(idle, 207);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/membus_arbiter_2to1.md
Name: membus_arbiter_2to1

Overview:
- Two-master to one-slave arbiter on the membus protocol. Sits directly upstream of the core's main word-addressed memory.
- Master I: instruction fetch. Master D: load/store unit.
- Forwards one request per cycle to the memory and tracks in-flight ownership in an in-order queue. Routes each slave response (rvalid/rdata) back to the master that issued it.

Parameters:
- ADDR_WIDTH, 20, word-address width of every bus.
- DATA_WIDTH, 32, data width of every bus.
- MAX_OUTSTANDING, 2, depth of the owner queue (legal 1..8).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-low reset (0 = reset)
- i_valid  in  1  master I request
- i_ready  out  1  master I request accepted this cycle
- i_addr  in  ADDR_WIDTH  master I word address
- i_wen  in  1  master I write enable
- i_wdata  in  DATA_WIDTH  master I write data
- i_rvalid  out  1  master I response
- i_rdata  out  DATA_WIDTH  master I response data
- d_valid, d_ready, d_addr, d_wen, d_wdata, d_rvalid, d_rdata: same as the i_* ports, for master D
- s_valid  out  1  request to memory
- s_ready  in  1  memory accepts request
- s_addr  out  ADDR_WIDTH  forwarded address
- s_wen  out  1  forwarded write enable
- s_wdata  out  DATA_WIDTH  forwarded write data
- s_rvalid  in  1  memory response, one per accepted request (writes included), returned in order
- s_rdata  in  DATA_WIDTH  memory response data
- busy  out  1  owner queue non-empty

Behaviour:
- Reset (rst=0, asynchronous):
  - Owner queue empty, lock cleared, priority pointer = D.
  - Outputs: s_valid=0, i_ready=0, d_ready=0, i_rvalid=0, d_rvalid=0, busy=0.
  - Forwarded data outputs are don't-care while s_valid=0.
- Request acceptance:
  - A request is accepted ("fires") on a cycle when s_valid && s_ready && queue not full (count < MAX_OUTSTANDING).
  - No bypass: a pop in the same cycle does not free a slot for that cycle's push.
- Grant selection (combinational):
  - If the lock is set, the locked master is granted.
  - Otherwise, if both masters are valid, D wins (fixed priority).
  - Otherwise, whichever master is valid is granted.
  - If neither is valid, s_valid=0.
- Request forwarding:
  - s_valid = granted master's valid && queue not full.
  - s_addr, s_wen, s_wdata are muxed from the granted master.
  - Granted master's ready = s_ready && queue not full. The other master's ready = 0.
- Lock:
  - Set when s_valid=1 and s_ready=0; records the granted master.
  - Cleared on the cycle the locked request fires.
  - Guarantees the memory sees stable addr/wen/wdata until acceptance.
  - Masters must hold valid and payload until ready; dropping valid while locked is a protocol violation (simulation assertion).
  - When the queue is full, s_valid is forced to 0 and the lock is not set.
- Owner queue:
  - Circular buffer of 1-bit owner IDs (0=I, 1=D) with read/write pointers and a count of clog2(MAX_OUTSTANDING+1) bits.
  - Pointers wrap modulo MAX_OUTSTANDING.
  - Push on fire; pop on s_rvalid.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- Response routing:
  - Same cycle as s_rvalid, combinational: head owner's rvalid = s_rvalid; other master's rvalid = 0.
  - i_rdata = d_rdata = s_rdata, unconditionally.
- Orphan response:
  - s_rvalid while the queue is empty (e.g. a response to a request issued before reset) is dropped.
  - Neither rvalid is raised and the queue is unchanged. Simulation warning only.
- Throughput:
  - Against a 1-cycle-latency, always-ready memory with MAX_OUTSTANDING >= 2: one request per cycle, zero added latency.
  - With MAX_OUTSTANDING=1: one request every 2 cycles.

Optional Feature:
- Macro: MEMBUS_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - When both masters are valid and the lock is clear, the master named by the priority pointer wins.
  - The pointer flips to the other master after every fire of a contested grant.
  - Uncontested fires leave the pointer unchanged.
  - Pointer resets to D.
- Undefined: fixed D>I priority; the pointer flop is not present.

Test Plan:
- Single read: memory word 0x00010 = 0xDEADBEEF; I reads 0x00010 with s_ready=1, 1-cycle memory -> i_ready=1 at T0; i_rvalid=1, i_rdata=0xDEADBEEF at T1; d_rvalid stays 0; busy 1 for one cycle.
- Contention: I and D both valid every cycle for 4 cycles, addresses 0x100 and 0x200 -> default build: all 4 fires are D, i_ready=0 throughout. With MEMBUS_ARBITER_ROUND_ROBIN_EN: fire order D,I,D,I and rvalids routed in the same order.
- Lock: I valid at 0x004 with s_ready=0 for 3 cycles; D raises valid in cycle 2 -> s_addr stays 0x004 all 3 cycles; I fires when s_ready=1; D fires the following cycle.
- Queue full: MAX_OUTSTANDING=2, memory response delayed 4 cycles, D issues reads back-to-back -> 2 fires, then s_valid=0 and d_ready=0 until the first s_rvalid; third fire occurs the cycle after that pop.
- Write then read: D writes 0x1234_5678 to 0x3FF then reads 0x3FF -> d_rvalid for the write ignored by the master; read returns 0x12345678; the I side sees no rvalid.
- Reset mid-operation: rst=0 asserted with 2 requests in flight, released, then memory delivers 2 stale rvalids -> both dropped; i_rvalid=d_rvalid=0; busy=0; next new request routes correctly.
